// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: opcode encoding and
// the burst controller's state encoding.
package usr_pkg;

    typedef enum logic [2:0] {
        OP_HOLD  = 3'b000,
        OP_LOAD  = 3'b001,
        OP_SHL   = 3'b010,
        OP_SHR   = 3'b011,
        OP_ASR   = 3'b100,
        OP_ROL   = 3'b101,
        OP_ROR   = 3'b110,
        OP_BURST = 3'b111
    } usr_op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } usr_state_e;

endpackage

// File: rtl/usr_burst_ctrl.sv
// Burst controller for univ_shift_reg_n: owns the IDLE/SHIFT state, the
// down-counter and the busy/done handshake. Emits shift_en for each edge
// on which the datapath must shift right during a burst; the final edge
// of a burst (counter at zero) holds q and raises done.
module usr_burst_ctrl
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic done,
    output logic shift_en
);

    localparam int CNT_W = $clog2(WIDTH);

    usr_state_e       state;
    usr_state_e       state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             busy_d;
    logic             done_d;

    // State, counter and registered handshake flags; reset aborts any burst.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

    // Next-state logic: accept a start in IDLE, count down in SHIFT,
    // and pulse done on the edge that returns to IDLE.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        busy_d   = busy;
        done_d   = 1'b0;
        shift_en = 1'b0;
        case (state)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d = ST_SHIFT;
                    cnt_d   = CNT_W'(WIDTH - 1);
                    busy_d  = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (cnt != '0) begin
                    shift_en = 1'b1;
                    cnt_d    = cnt - 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/univ_shift_reg_n.sv
// Universal shift register, WIDTH bits: hold, load, shift left/right with
// serial fill, arithmetic shift right, optional rotates, and an LSB-first
// burst serialiser on ser_out driven by usr_burst_ctrl.
// Build option: define USR_ROTATE_EN to enable ROL/ROR (opcodes 101/110);
// without it those opcodes behave as HOLD and no rotate logic is built.
module univ_shift_reg_n
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ser_in_l,
    input  logic             ser_in_r,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    logic [WIDTH-1:0] q_d;
    logic             start;
    logic             shift_en;
    usr_op_e          op_e;

    assign op_e    = usr_op_e'(op);
    assign start   = ~busy && (op_e == OP_BURST);
    assign ser_out = q[0];

    usr_burst_ctrl #(
        .WIDTH (WIDTH)
    ) u_burst_ctrl (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .shift_en (shift_en)
    );

    // Register contents; cleared asynchronously so ser_out is 0 in reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= q_d;
        end
    end

    // Opcode mux: burst shifting has priority; ops are decoded only while idle.
    always_comb begin
        q_d = q;
        if (shift_en) begin
            q_d = {ser_in_r, q[WIDTH-1:1]};
        end else if (!busy) begin
            case (op_e)
                OP_LOAD:  q_d = data_in;
                OP_SHL:   q_d = {q[WIDTH-2:0], ser_in_l};
                OP_SHR:   q_d = {ser_in_r, q[WIDTH-1:1]};
                OP_ASR:   q_d = {q[WIDTH-1], q[WIDTH-1:1]};
`ifdef USR_ROTATE_EN
                OP_ROL:   q_d = {q[WIDTH-2:0], q[WIDTH-1]};
                OP_ROR:   q_d = {q[0], q[WIDTH-1:1]};
`endif
                OP_BURST: q_d = data_in;
                default:  q_d = q;
            endcase
        end
    end

endmodule

// File: tb/tb_univ_shift_reg_n.sv
// Directed self-checking bench for univ_shift_reg_n (WIDTH=8).
module tb_univ_shift_reg_n;

    localparam int W = 8;

    localparam logic [2:0] HOLD  = 3'b000;
    localparam logic [2:0] LOAD  = 3'b001;
    localparam logic [2:0] SHL   = 3'b010;
    localparam logic [2:0] SHR   = 3'b011;
    localparam logic [2:0] ASR   = 3'b100;
    localparam logic [2:0] ROL   = 3'b101;
    localparam logic [2:0] ROR   = 3'b110;
    localparam logic [2:0] BURST = 3'b111;

    logic         clk;
    logic         reset;
    logic [2:0]   op;
    logic [W-1:0] data_in;
    logic         ser_in_l;
    logic         ser_in_r;
    logic [W-1:0] q;
    logic         ser_out;
    logic         busy;
    logic         done;

    int n_tests = 0;
    int n_fail  = 0;

    univ_shift_reg_n #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .data_in  (data_in),
        .ser_in_l (ser_in_l),
        .ser_in_r (ser_in_r),
        .q        (q),
        .ser_out  (ser_out),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [2:0] o, input logic [W-1:0] d);
        op      = o;
        data_in = d;
        tick();
        op      = HOLD;
    endtask

    // Run a burst already accepted (we are in busy cycle 1); check each
    // serial bit, the done pulse, and the final register value.
    task automatic run_burst(input string tag, input logic [W-1:0] word,
                             input logic [W-1:0] final_q, input bit inject_load);
        for (int k = 1; k <= W; k++) begin
            chk($sformatf("%s busy c%0d", tag, k), busy, 1'b1);
            chk($sformatf("%s ser c%0d", tag, k), ser_out, word[k-1]);
            chk($sformatf("%s done c%0d", tag, k), done, 1'b0);
            if (inject_load && k == 3) begin
                op      = LOAD;
                data_in = 8'hFF;
            end else begin
                op      = HOLD;
            end
            tick();
        end
        op = HOLD;
        chk({tag, " done pulse"}, done, 1'b1);
        chk({tag, " busy end"}, busy, 1'b0);
        chk({tag, " final q"}, q, final_q);
    endtask

    initial begin
        bit done_seen;
        bit busy_seen;

        reset    = 1'b1;
        op       = HOLD;
        data_in  = '0;
        ser_in_l = 1'b0;
        ser_in_r = 1'b0;
        #3;
        chk("rst q", q, 8'h00);
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst ser_out", ser_out, 1'b0);
        tick();
        reset = 1'b0;
        tick();

        // Basic ops
        do_op(LOAD, 8'hA5);
        chk("load A5", q, 8'hA5);
        do_op(HOLD, 8'h00);
        chk("hold", q, 8'hA5);
        ser_in_l = 1'b1;
        do_op(SHL, 8'h00);
        chk("shl fill1", q, 8'h4B);
        ser_in_l = 1'b0;
        ser_in_r = 1'b1;
        do_op(SHR, 8'h00);
        chk("shr fill1", q, 8'hA5);
        ser_in_r = 1'b0;
        do_op(SHR, 8'h00);
        chk("shr fill0", q, 8'h52);
        chk("ser_out lsb", ser_out, 1'b0);

        do_op(LOAD, 8'h80);
        do_op(ASR, 8'h00);
        chk("asr 1", q, 8'hC0);
        do_op(ASR, 8'h00);
        chk("asr 2", q, 8'hE0);

        do_op(LOAD, 8'h81);
        do_op(ROL, 8'h00);
`ifdef USR_ROTATE_EN
        chk("rol 81", q, 8'h03);
`else
        chk("rol 81 off", q, 8'h81);
`endif
        do_op(LOAD, 8'h81);
        do_op(ROR, 8'h00);
`ifdef USR_ROTATE_EN
        chk("ror 81", q, 8'hC0);
`else
        chk("ror 81 off", q, 8'h81);
`endif

        // Burst 0xB4, LOAD injected in busy cycle 3 must be ignored
        ser_in_r = 1'b0;
        chk("idle before burst", busy, 1'b0);
        do_op(BURST, 8'hB4);
        run_burst("b4", 8'hB4, 8'h01, 1'b1);

        // Back-to-back burst issued in the done cycle, fill 1
        ser_in_r = 1'b1;
        do_op(BURST, 8'h3C);
        chk("b2b no gap", busy, 1'b1);
        run_burst("b2b", 8'h3C, 8'hFE, 1'b0);
        tick();
        chk("done one cycle", done, 1'b0);
        ser_in_r = 1'b0;

        // Reset in busy cycle 4 aborts the burst immediately
        do_op(BURST, 8'h5A);
        tick();
        tick();
        tick();
        chk("abort pre busy", busy, 1'b1);
        reset = 1'b1;
        #2;
        chk("abort busy", busy, 1'b0);
        chk("abort q", q, 8'h00);
        chk("abort done", done, 1'b0);
        chk("abort ser_out", ser_out, 1'b0);
        tick();
        reset = 1'b0;
        done_seen = 1'b0;
        busy_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) done_seen = 1'b1;
            if (busy) busy_seen = 1'b1;
        end
        chk("no done after abort", done_seen, 1'b0);
        chk("no busy after abort", busy_seen, 1'b0);

        do_op(BURST, 8'h0F);
        run_burst("0f", 8'h0F, 8'h00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
